bp_fe_ltb: RTL and testbench

BP_FE_LTB -- requirements
Module: bp_fe_ltb

---
 rtl/bp_fe_ltb.sv | 276 +++++++++++++++++++++++++++
 tb/tb_bp_fe_ltb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_ltb.sv
// bp_fe_ltb -- loop termination buffer for the front-end branch predictor.
//
// Learns, per loop-closing branch, how many times it is taken before it
// falls through (trip count). Once a trip count has been seen twice in a
// row the entry becomes confident, and lookups then predict the exit
// iteration.
//
// Build option: define BP_FE_LTB_SPEC_CNT_EN to keep a speculative
// iteration counter per entry. The counter advances on every lookup hit and
// is resynchronised to the committed count on a mispredict. Without the
// macro, predictions use the committed count only, lookups never modify
// the table, and r_spec_cnt_o / w_spec_cnt_o are tied to zero.
//
// Ports:
//   clk_i, reset_li       clock, asynchronous active-low reset
//   init_done_o           table clear sweep finished
//   r_v_i, r_addr_i       lookup request and PC
//   pred_*_o, r_spec_cnt_o  lookup result, registered, one cycle later
//   w_v_i, br_*_i         resolved-branch update
//   w_yumi_o              update accepted this cycle (combinational)
//   w_spec_cnt_o          post-update speculative count, valid with w_yumi_o
module bp_fe_ltb
  #(parameter int vaddr_width_p   = 39
   ,parameter int ltb_els_p       = 16
   ,parameter int ltb_tag_width_p = 10
   ,parameter int ltb_cnt_width_p = 4
  )
  (input  logic                       clk_i
  ,input  logic                       reset_li
  ,output logic                       init_done_o
  ,input  logic                       r_v_i
  ,input  logic [vaddr_width_p-1:0]   r_addr_i
  ,output logic                       pred_v_o
  ,output logic                       pred_taken_o
  ,output logic                       pred_conf_o
  ,output logic [ltb_cnt_width_p-1:0] pred_non_spec_cnt_o
  ,output logic [ltb_cnt_width_p-1:0] pred_trip_cnt_o
  ,output logic [ltb_cnt_width_p-1:0] r_spec_cnt_o
  ,input  logic                       w_v_i
  ,input  logic [vaddr_width_p-1:0]   br_src_addr_i
  ,input  logic                       br_taken_i
  ,input  logic                       br_mispredict_i
  ,output logic                       w_yumi_o
  ,output logic [ltb_cnt_width_p-1:0] w_spec_cnt_o
  );

  localparam int idx_width_lp = $clog2(ltb_els_p);
  localparam int tag_lsb_lp   = 1 + idx_width_lp;
  localparam int tag_msb_lp   = tag_lsb_lp + ltb_tag_width_p - 1;

  localparam logic [0:0] e_clear = 1'b0;
  localparam logic [0:0] e_run   = 1'b1;

  localparam logic [idx_width_lp-1:0]    last_idx_lp = {idx_width_lp{1'b1}};
  localparam logic [idx_width_lp-1:0]    idx_zero_lp = {idx_width_lp{1'b0}};
  localparam logic [ltb_cnt_width_p-1:0] cnt_zero_lp = {ltb_cnt_width_p{1'b0}};
  localparam logic [ltb_cnt_width_p-1:0] cnt_one_lp  = {{(ltb_cnt_width_p-1){1'b0}}, 1'b1};

  logic [0:0]              state_q, state_d;
  logic [idx_width_lp-1:0] clr_idx_q, clr_idx_d;

  // Table storage; only the valid bits need a reset value
  logic [ltb_els_p-1:0]       valid_q, valid_d;
  logic [ltb_els_p-1:0]       conf_q, conf_d;
  logic [ltb_tag_width_p-1:0] tag_q [ltb_els_p];
  logic [ltb_tag_width_p-1:0] tag_d [ltb_els_p];
  logic [ltb_cnt_width_p-1:0] non_spec_q [ltb_els_p];
  logic [ltb_cnt_width_p-1:0] non_spec_d [ltb_els_p];
  logic [ltb_cnt_width_p-1:0] trip_q [ltb_els_p];
  logic [ltb_cnt_width_p-1:0] trip_d [ltb_els_p];

  logic                       pred_v_q, pred_v_d;
  logic                       pred_taken_q, pred_taken_d;
  logic                       pred_conf_q, pred_conf_d;
  logic [ltb_cnt_width_p-1:0] pred_non_spec_cnt_q, pred_non_spec_cnt_d;
  logic [ltb_cnt_width_p-1:0] pred_trip_cnt_q, pred_trip_cnt_d;

  logic [idx_width_lp-1:0]    r_idx, w_idx;
  logic [ltb_tag_width_p-1:0] r_tag, w_tag;
  logic                       r_hit, w_hit, in_run;
  logic [ltb_cnt_width_p-1:0] r_ns_inc, w_ns_inc;
  logic                       unused_addr_bits;

  assign r_idx  = r_addr_i[1 +: idx_width_lp];
  assign r_tag  = r_addr_i[tag_lsb_lp +: ltb_tag_width_p];
  assign w_idx  = br_src_addr_i[1 +: idx_width_lp];
  assign w_tag  = br_src_addr_i[tag_lsb_lp +: ltb_tag_width_p];
  assign in_run = (state_q == e_run);
  assign r_hit  = valid_q[r_idx] & (tag_q[r_idx] == r_tag);
  assign w_hit  = valid_q[w_idx] & (tag_q[w_idx] == w_tag);
  assign r_ns_inc = non_spec_q[r_idx] + cnt_one_lp;
  assign w_ns_inc = non_spec_q[w_idx] + cnt_one_lp;

  // A same-index lookup wins; the update retries next cycle
  assign w_yumi_o    = w_v_i & in_run & ~(r_v_i & (r_idx == w_idx));
  assign init_done_o = in_run;

  assign pred_v_o            = pred_v_q;
  assign pred_taken_o        = pred_taken_q;
  assign pred_conf_o         = pred_conf_q;
  assign pred_non_spec_cnt_o = pred_non_spec_cnt_q;
  assign pred_trip_cnt_o     = pred_trip_cnt_q;

`ifdef BP_FE_LTB_SPEC_CNT_EN
  logic [ltb_cnt_width_p-1:0] spec_q [ltb_els_p];
  logic [ltb_cnt_width_p-1:0] spec_d [ltb_els_p];
  logic [ltb_cnt_width_p-1:0] r_spec_cnt_q, r_spec_cnt_d;
  logic [ltb_cnt_width_p-1:0] r_spec_inc;
  logic [ltb_cnt_width_p-1:0] w_spec_cnt;

  assign r_spec_inc   = spec_q[r_idx] + cnt_one_lp;
  assign r_spec_cnt_o = r_spec_cnt_q;
  assign w_spec_cnt_o = w_spec_cnt;
  assign unused_addr_bits = ^{r_addr_i[vaddr_width_p-1:tag_msb_lp+1], r_addr_i[0],
                              br_src_addr_i[vaddr_width_p-1:tag_msb_lp+1], br_src_addr_i[0]};
`else
  assign r_spec_cnt_o = cnt_zero_lp;
  assign w_spec_cnt_o = cnt_zero_lp;
  assign unused_addr_bits = ^{r_addr_i[vaddr_width_p-1:tag_msb_lp+1], r_addr_i[0],
                              br_src_addr_i[vaddr_width_p-1:tag_msb_lp+1], br_src_addr_i[0],
                              br_mispredict_i};
`endif

  // Next-state: clear sweep, lookup result, speculative advance, update
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    valid_d    = valid_q;
    conf_d     = conf_q;
    tag_d      = tag_q;
    non_spec_d = non_spec_q;
    trip_d     = trip_q;
    pred_v_d            = 1'b0;
    pred_taken_d        = 1'b0;
    pred_conf_d         = 1'b0;
    pred_non_spec_cnt_d = cnt_zero_lp;
    pred_trip_cnt_d     = cnt_zero_lp;
`ifdef BP_FE_LTB_SPEC_CNT_EN
    spec_d       = spec_q;
    r_spec_cnt_d = cnt_zero_lp;
    w_spec_cnt   = cnt_zero_lp;
`endif

    case (state_q)
      e_clear: begin
        valid_d[clr_idx_q] = 1'b0;
        if (clr_idx_q == last_idx_lp) begin
          state_d   = e_run;
          clr_idx_d = idx_zero_lp;
        end else begin
          clr_idx_d = clr_idx_q + {{(idx_width_lp-1){1'b0}}, 1'b1};
        end
      end
      e_run: begin
        state_d = e_run;
      end
      default: begin
        state_d   = e_clear;
        clr_idx_d = idx_zero_lp;
      end
    endcase

    if (r_v_i & in_run & r_hit) begin
      pred_v_d            = conf_q[r_idx];
      pred_conf_d         = conf_q[r_idx];
      pred_non_spec_cnt_d = non_spec_q[r_idx];
      pred_trip_cnt_d     = trip_q[r_idx];
`ifdef BP_FE_LTB_SPEC_CNT_EN
      // Exit iteration reached: predict fall-through and restart the count
      if (conf_q[r_idx] & (r_spec_inc == trip_q[r_idx])) begin
        pred_taken_d  = 1'b0;
        spec_d[r_idx] = cnt_zero_lp;
        r_spec_cnt_d  = cnt_zero_lp;
      end else begin
        pred_taken_d  = 1'b1;
        spec_d[r_idx] = r_spec_inc;
        r_spec_cnt_d  = r_spec_inc;
      end
`else
      pred_taken_d = ~(conf_q[r_idx] & (r_ns_inc == trip_q[r_idx]));
`endif
    end else begin
      pred_v_d = 1'b0;
    end

    // w_yumi_o guarantees w_idx differs from any same-cycle lookup index
    if (w_yumi_o) begin
      if (w_hit) begin
        if (br_taken_i) begin
          // Committed count would overflow: the loop is too long to track
          if (&non_spec_q[w_idx]) begin
            valid_d[w_idx] = 1'b0;
          end else begin
            non_spec_d[w_idx] = w_ns_inc;
`ifdef BP_FE_LTB_SPEC_CNT_EN
            if (br_mispredict_i) begin
              spec_d[w_idx] = w_ns_inc;
            end else begin
              spec_d[w_idx] = spec_q[w_idx];
            end
            w_spec_cnt = spec_d[w_idx];
`endif
          end
        end else begin
          // Loop exit: confident only if this trip repeats the last one
          conf_d[w_idx]     = (trip_q[w_idx] == w_ns_inc);
          trip_d[w_idx]     = w_ns_inc;
          non_spec_d[w_idx] = cnt_zero_lp;
`ifdef BP_FE_LTB_SPEC_CNT_EN
          if (br_mispredict_i) begin
            spec_d[w_idx] = cnt_zero_lp;
          end else begin
            spec_d[w_idx] = spec_q[w_idx];
          end
          w_spec_cnt = spec_d[w_idx];
`endif
        end
      end else if (br_taken_i) begin
        valid_d[w_idx]    = 1'b1;
        tag_d[w_idx]      = w_tag;
        conf_d[w_idx]     = 1'b0;
        non_spec_d[w_idx] = cnt_one_lp;
        trip_d[w_idx]     = cnt_zero_lp;
`ifdef BP_FE_LTB_SPEC_CNT_EN
        spec_d[w_idx] = cnt_one_lp;
        w_spec_cnt    = cnt_one_lp;
`endif
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_d;
    end
  end

  // Control state, valid bits and registered lookup outputs
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      state_q             <= e_clear;
      clr_idx_q           <= idx_zero_lp;
      valid_q             <= {ltb_els_p{1'b0}};
      pred_v_q            <= 1'b0;
      pred_taken_q        <= 1'b0;
      pred_conf_q         <= 1'b0;
      pred_non_spec_cnt_q <= cnt_zero_lp;
      pred_trip_cnt_q     <= cnt_zero_lp;
`ifdef BP_FE_LTB_SPEC_CNT_EN
      r_spec_cnt_q        <= cnt_zero_lp;
`endif
    end else begin
      state_q             <= state_d;
      clr_idx_q           <= clr_idx_d;
      valid_q             <= valid_d;
      pred_v_q            <= pred_v_d;
      pred_taken_q        <= pred_taken_d;
      pred_conf_q         <= pred_conf_d;
      pred_non_spec_cnt_q <= pred_non_spec_cnt_d;
      pred_trip_cnt_q     <= pred_trip_cnt_d;
`ifdef BP_FE_LTB_SPEC_CNT_EN
      r_spec_cnt_q        <= r_spec_cnt_d;
`endif
    end
  end

  // Entry payload; meaningless while the valid bit is clear
  always_ff @(posedge clk_i) begin
    conf_q     <= conf_d;
    tag_q      <= tag_d;
    non_spec_q <= non_spec_d;
    trip_q     <= trip_d;
`ifdef BP_FE_LTB_SPEC_CNT_EN
    spec_q     <= spec_d;
`endif
  end

endmodule

// File: tb/tb_bp_fe_ltb.sv
// Randomised scoreboard bench for bp_fe_ltb. The driver applies one request
// per cycle and queues what the loop-buffer rules say must appear; a monitor
// on the falling edge pops and compares whenever the tagged cycle arrives.
module tb_bp_fe_ltb;
  localparam int VW   = 39;
  localparam int ELS  = 16;
  localparam int TW   = 10;
  localparam int CW   = 4;
  localparam int IW   = $clog2(ELS);
  localparam int CMOD = 1 << CW;
`ifdef BP_FE_LTB_SPEC_CNT_EN
  localparam bit SPEC_EN = 1'b1;
`else
  localparam bit SPEC_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_li = 1'b0;
  logic          init_done_o;
  logic          r_v_i = 1'b0;
  logic [VW-1:0] r_addr_i = '0;
  logic          pred_v_o, pred_taken_o, pred_conf_o;
  logic [CW-1:0] pred_non_spec_cnt_o, pred_trip_cnt_o, r_spec_cnt_o;
  logic          w_v_i = 1'b0;
  logic [VW-1:0] br_src_addr_i = '0;
  logic          br_taken_i = 1'b0;
  logic          br_mispredict_i = 1'b0;
  logic          w_yumi_o;
  logic [CW-1:0] w_spec_cnt_o;

  bp_fe_ltb #(.vaddr_width_p(VW), .ltb_els_p(ELS), .ltb_tag_width_p(TW), .ltb_cnt_width_p(CW)) dut (
    .clk_i(clk_i), .reset_li(reset_li), .init_done_o(init_done_o),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i),
    .pred_v_o(pred_v_o), .pred_taken_o(pred_taken_o), .pred_conf_o(pred_conf_o),
    .pred_non_spec_cnt_o(pred_non_spec_cnt_o), .pred_trip_cnt_o(pred_trip_cnt_o),
    .r_spec_cnt_o(r_spec_cnt_o),
    .w_v_i(w_v_i), .br_src_addr_i(br_src_addr_i), .br_taken_i(br_taken_i),
    .br_mispredict_i(br_mispredict_i), .w_yumi_o(w_yumi_o), .w_spec_cnt_o(w_spec_cnt_o));

  always #5 clk_i = ~clk_i;

  typedef struct { int cyc; int v; int taken; int conf; int ns; int trip; int rspec; } pred_exp_t;
  typedef struct { int cyc; int yumi; int done; int wspec; } w_exp_t;
  typedef struct { bit valid; int tag; bit conf; int spec; int ns; int trip; } ent_t;

  pred_exp_t pred_q[$];
  w_exp_t    w_q[$];
  ent_t      tbl[ELS];
  int        clear_left = 0;
  int        n_tests = 0;
  int        n_fail = 0;
  int        cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectation
  always @(negedge clk_i) begin
    if (w_q.size() > 0 && w_q[0].cyc == cyc) begin
      w_exp_t e;
      e = w_q.pop_front();
      chk("w_yumi", int'(w_yumi_o), e.yumi);
      chk("w_spec_cnt", int'(w_spec_cnt_o), e.wspec);
      chk("init_done", int'(init_done_o), e.done);
    end
    if (pred_q.size() > 0 && pred_q[0].cyc == cyc) begin
      pred_exp_t p;
      p = pred_q.pop_front();
      chk("pred_v", int'(pred_v_o), p.v);
      chk("pred_taken", int'(pred_taken_o), p.taken);
      chk("pred_conf", int'(pred_conf_o), p.conf);
      chk("pred_non_spec", int'(pred_non_spec_cnt_o), p.ns);
      chk("pred_trip", int'(pred_trip_cnt_o), p.trip);
      chk("r_spec_cnt", int'(r_spec_cnt_o), p.rspec);
    end else begin
      chk("pred_v_idle", int'(pred_v_o), 0);
    end
  end

  function automatic logic [VW-1:0] mk_addr(input int idx, input int tag);
    logic [VW-1:0] a;
    a = {$urandom, $urandom};
    a[1 +: IW] = IW'(idx);
    a[1+IW +: TW] = TW'(tag);
    return a;
  endfunction

  // One cycle of stimulus plus the reference behaviour of the loop buffer
  task automatic step(input bit rv, input logic [VW-1:0] ra, input bit wv,
                      input logic [VW-1:0] wa, input bit tk, input bit mp);
    pred_exp_t pe;
    w_exp_t we;
    int ri, rt, wi, wt, nxt;
    bit run, rd_hit;
    @(posedge clk_i); #1;
    r_v_i = rv; r_addr_i = ra; w_v_i = wv; br_src_addr_i = wa;
    br_taken_i = tk; br_mispredict_i = mp;
    if (clear_left > 0) clear_left--;
    run = (clear_left == 0);
    ri = int'((ra >> 1) % ELS);  rt = int'((ra >> (1 + IW)) % (1 << TW));
    wi = int'((wa >> 1) % ELS);  wt = int'((wa >> (1 + IW)) % (1 << TW));

    pe = '{cyc: cyc + 1, v: 0, taken: 0, conf: 0, ns: 0, trip: 0, rspec: 0};
    rd_hit = rv && run && tbl[ri].valid && tbl[ri].tag == rt;
    nxt = 0;
    if (rd_hit) begin
      pe.v = tbl[ri].conf; pe.conf = tbl[ri].conf;
      pe.ns = tbl[ri].ns;  pe.trip = tbl[ri].trip;
      if (SPEC_EN) begin
        nxt = (tbl[ri].spec + 1) % CMOD;
        if (tbl[ri].conf && nxt == tbl[ri].trip) begin pe.taken = 0; nxt = 0; end
        else pe.taken = 1;
        pe.rspec = nxt;
      end else begin
        pe.taken = (tbl[ri].conf && (tbl[ri].ns + 1) % CMOD == tbl[ri].trip) ? 0 : 1;
      end
    end
    if (rv) pred_q.push_back(pe);

    we = '{cyc: cyc, yumi: 0, done: int'(run), wspec: 0};
    we.yumi = int'(wv && run && !(rv && ri == wi));
    if (we.yumi != 0) begin
      if (tbl[wi].valid && tbl[wi].tag == wt) begin
        if (tk) begin
          if (tbl[wi].ns == CMOD - 1) tbl[wi].valid = 1'b0;
          else begin
            tbl[wi].ns = tbl[wi].ns + 1;
            if (mp) tbl[wi].spec = tbl[wi].ns;
            we.wspec = SPEC_EN ? tbl[wi].spec : 0;
          end
        end else begin
          tbl[wi].conf = (tbl[wi].trip == (tbl[wi].ns + 1) % CMOD);
          tbl[wi].trip = (tbl[wi].ns + 1) % CMOD;
          tbl[wi].ns = 0;
          if (mp) tbl[wi].spec = 0;
          we.wspec = SPEC_EN ? tbl[wi].spec : 0;
        end
      end else if (tk) begin
        tbl[wi] = '{valid: 1'b1, tag: wt, conf: 1'b0, spec: 1, ns: 1, trip: 0};
        we.wspec = SPEC_EN ? 1 : 0;
      end
    end
    w_q.push_back(we);
    if (rd_hit && SPEC_EN) tbl[ri].spec = nxt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse of one cycle; outputs must drop before any edge
  task automatic do_reset();
    @(posedge clk_i); #1;
    reset_li = 1'b0;
    r_v_i = 1'b0; w_v_i = 1'b0; br_taken_i = 1'b0; br_mispredict_i = 1'b0;
    pred_q.delete(); w_q.delete();
    #1;
    chk("rst_init_done", int'(init_done_o), 0);
    chk("rst_pred_v", int'(pred_v_o), 0);
    chk("rst_pred_taken", int'(pred_taken_o), 0);
    chk("rst_pred_conf", int'(pred_conf_o), 0);
    chk("rst_pred_trip", int'(pred_trip_cnt_o), 0);
    chk("rst_r_spec_cnt", int'(r_spec_cnt_o), 0);
    @(posedge clk_i); #1;
    reset_li = 1'b1;
    for (int i = 0; i < ELS; i++) tbl[i].valid = 1'b0;
    clear_left = ELS;
  endtask

  logic [VW-1:0] a80, a104, a_loop, a_other;

  initial begin
    a80 = {{(VW-8){1'b0}}, 8'h80};
    do_reset();
    // Lookups and updates during the clear sweep are ignored
    for (int i = 0; i < ELS + 2; i++)
      step(1'b1, a80, 1'b1, mk_addr(i % ELS, 3), 1'b1, 1'b0);

    // Loop of three iterations: T,T,N twice makes the entry confident
    for (int r = 0; r < 2; r++) begin
      step(1'b0, '0, 1'b1, a80, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, a80, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, a80, 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b1, a80, 1'b0, '0, 1'b0, 1'b0);

    // Same-index collision: read wins, update accepted the cycle after
    a_other = mk_addr(5, 9);
    step(1'b1, mk_addr(5, 1), 1'b1, a_other, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, a_other, 1'b1, 1'b0);

    // Counter saturation invalidates the entry
    a104 = {{(VW-12){1'b0}}, 12'h104};
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, a104, 1'b1, 1'b0);
    step(1'b1, a104, 1'b0, '0, 1'b0, 1'b0);

    // Mispredict resynchronises the speculative count to the committed one
    a_loop = mk_addr(7, 22);
    step(1'b0, '0, 1'b1, a_loop, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, a_loop, 1'b0, 1'b0);
    step(1'b1, a_loop, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, a_loop, 1'b1, 1'b1);

    // Reset mid-run right behind a confident hit
    step(1'b1, a80, 1'b0, '0, 1'b0, 1'b0);
    do_reset();
    idle(ELS);
    step(1'b1, a80, 1'b0, '0, 1'b0, 1'b0);

    // Random traffic over a small set of indices and tags
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 3), $urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), mk_addr($urandom_range(0, 3), $urandom_range(0, 1)),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0));
      if (i == 700) do_reset();
    end
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
